// File: rtl/btn_debounce_if.sv
// Bundle of raw pin inputs and conditioned outputs for btn_debounce.
// The slave side is the debouncer; the master side is whoever drives the raw pins.
interface btn_debounce_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] raw_i;
    logic [N_CH-1:0] deb_o;
    logic [N_CH-1:0] rise_o;
    logic [N_CH-1:0] fall_o;
    logic [N_CH-1:0] long_o;

    modport master (output raw_i, input deb_o, rise_o, fall_o, long_o);
    modport slave  (input raw_i, output deb_o, rise_o, fall_o, long_o);
endinterface

// File: rtl/btn_debounce.sv
// Per-channel 2-flop synchroniser, counter debouncer and registered edge pulses.
// Optional long-press detection is built when LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int   N_CH       = 2,
    parameter int   CNT_W      = 14,
    parameter int   STABLE_CNT = 10000,
    parameter logic RST_LVL    = 1'b1,
    parameter int   LONG_W     = 20,
    parameter int   LONG_CNT   = 500000
) (
    input  logic          pG0,
    input  logic          pRST,
    btn_debounce_if.slave bus
);

    localparam logic [0:0]       ST_STABLE = 1'b0;
    localparam logic [0:0]       ST_WAIT   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);
`ifdef LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LIM = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CNT - 1);
`endif

    logic [N_CH-1:0] s1_q;
    logic [N_CH-1:0] s2_q;

    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            s1_q <= {N_CH{RST_LVL}};
            s2_q <= {N_CH{RST_LVL}};
        end else begin
            s1_q <= bus.raw_i;
            s2_q <= s1_q;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [0:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, deb_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // The first differing sample is counted on entry to WAIT, so a one-sample
        // threshold has to accept straight from STABLE.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            deb_d   = deb_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (state_q == ST_STABLE) begin
                cnt_d = '0;
                if (s2_q[ch] != deb_q) begin
                    if (STABLE_CNT == 1) begin
                        deb_d  = s2_q[ch];
                        rise_d = s2_q[ch];
                        fall_d = !s2_q[ch];
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end else begin
                if (s2_q[ch] == deb_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    deb_d   = s2_q[ch];
                    rise_d  = s2_q[ch];
                    fall_d  = !s2_q[ch];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge pG0 or negedge pRST) begin
            if (!pRST) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                deb_q   <= RST_LVL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                deb_q   <= deb_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign bus.deb_o[ch]  = deb_q;
        assign bus.rise_o[ch] = rise_q;
        assign bus.fall_o[ch] = fall_q;

`ifdef LONG_PRESS_EN
        logic [LONG_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;

        // Saturating at the limit is what guarantees a single pulse per press.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (deb_q == RST_LVL) begin
                hold_d = '0;
            end else if (hold_q != LONG_LIM) begin
                hold_d = hold_q + LONG_W'(1);
                long_d = (hold_q == LONG_PRE);
            end
        end

        always_ff @(posedge pG0 or negedge pRST) begin
            if (!pRST) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign bus.long_o[ch] = long_q;
`else
        assign bus.long_o[ch] = 1'b0;
`endif
    end

endmodule
